cdc_tx_arbiter: RTL and testbench
=================================

CDC_TX_ARBITER -- requirements
Module: cdc_tx_arbiter

Interface
REQ-001 Parameter BUS_WIDTH, default 8: width of the shared synchronized data bus.
REQ-002 Parameter NUM_STAGES, default 2: flop stages in the internal dest_ack synchronizer, minimum 2.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles spent waiting on one ack phase before abort, range 1..255.
REQ-004 CLK  input  1  source-domain clock; all logic SHALL be rising-edge clocked.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 req  input  2  per-requester transfer request, level; held high until the matching grant bit pulses.
REQ-007 req_data0  input  BUS_WIDTH  payload of requester 0.
REQ-008 req_data1  input  BUS_WIDTH  payload of requester 1.
REQ-009 grant  output  2  one-hot one-cycle pulse; payload captured for that requester.
REQ-010 sync_bus  output  BUS_WIDTH  registered payload driven to the destination domain.
REQ-011 bus_enable  output  1  registered level; the destination pulse generator edge-detects it.
REQ-012 dest_ack  input  1  asynchronous level from the destination; high means data captured.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse when a transfer is aborted.

Function
REQ-015 FSM states SHALL be IDLE, SEND and RELEASE, and only these.
REQ-016 dest_ack SHALL pass through NUM_STAGES flops; only the last stage (ack_s) SHALL feed logic.
REQ-017 In IDLE with any req bit high, the arbiter SHALL grant one requester, register its data into sync_bus, set bus_enable, pulse grant and move to SEND on the same edge.
REQ-018 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; the last-granted pointer resets to 1, so requester 0 wins first.
REQ-019 Latency: req sampled high in IDLE at edge n gives grant, sync_bus and bus_enable valid after edge n.
REQ-020 sync_bus SHALL stay constant from capture until the FSM returns to IDLE.
REQ-021 In SEND, ack_s high SHALL clear bus_enable and move to RELEASE.
REQ-022 In RELEASE, ack_s low SHALL move to IDLE; a new grant is possible on the following edge at the earliest.
REQ-023 An 8-bit wait counter SHALL clear on every state change; in SEND or RELEASE it SHALL increment each cycle while the awaited ack level is absent.
REQ-024 When the counter equals TIMEOUT, the block SHALL pulse timeout_err, clear bus_enable and go to IDLE; the pointer SHALL still advance.
REQ-025 req bits seen outside IDLE SHALL be ignored, and no grant SHALL issue there.
REQ-026 A requester that drops req before its grant SHALL lose its slot, and no grant SHALL issue for it.
REQ-027 ack_s already high in IDLE SHALL have no effect; SEND ignores it until a fresh rising level arrives after entry.
REQ-028 grant SHALL never have more than one bit high and SHALL be high for exactly one cycle per transfer.

Reset
REQ-029 RST low SHALL asynchronously force state IDLE, grant 0, sync_bus 0, bus_enable 0, busy 0, timeout_err 0, wait counter 0, synchronizer flops 0 and last-granted pointer 1.
REQ-030 Reset asserted mid-transfer SHALL abort with no grant or timeout_err pulse; the first request after release SHALL go to requester 0.

Structure
REQ-031 The FSM state encoding and the default TIMEOUT constant SHALL live in the shared CDC package.
REQ-032 The ack synchronizer SHALL be sub-module cdc_ack_sync (parameter NUM_STAGES); all other logic is flat.

Verification
REQ-033 Single transfer: req=01, req_data0=0xA5, ack raised 3 cycles after bus_enable and dropped 3 cycles after its fall -> grant=01 one cycle, sync_bus=0xA5 throughout, busy low again after RELEASE.
REQ-034 Contention: req=11 held across transfers -> grants 01, 10, 01 in order; sync_bus shows data0, data1, data0.
REQ-035 Timeout: TIMEOUT=10, dest_ack tied low -> timeout_err pulses 10 cycles after SEND entry, bus_enable low, state IDLE.
REQ-036 Mid-transfer reset: RST low during RELEASE -> all outputs 0 immediately; after release, req=11 -> grant=01.
REQ-037 Late request: req1 raised while in SEND -> no grant until IDLE, then grant=10 on the first IDLE edge.
REQ-038 Stale ack: dest_ack held high entering IDLE, then req=01 -> SEND waits until the ack toggles low then high, with no premature RELEASE.

Source files
------------

// File: rtl/cdc_tx_arbiter_pkg.sv
// cdc_tx_arbiter_pkg: shared CDC types and constants
// Holds the arbiter FSM state encoding, the wait-counter width and the default abort limit.
package cdc_tx_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_e;
    localparam int WAIT_W          = 8;
    localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/cdc_tx_arbiter_ack_sync.sv
// cdc_ack_sync: multi-flop level synchronizer for the destination acknowledge
// Ports: CLK rising-edge clock, RST async active-low reset,
//        d asynchronous input level, q synchronized level (last stage).
module cdc_ack_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);
    logic [NUM_STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[NUM_STAGES-2:0], d};

    always_ff @(posedge CLK or negedge RST)
        if (!RST) sync_q <= '0;
        else      sync_q <= sync_d;

    assign q = sync_q[NUM_STAGES-1];
endmodule

// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: two-requester round-robin arbiter driving a 4-phase handshake bus into another clock domain
// Ports: CLK/RST clock and async active-low reset; req[1:0] level requests with req_data0/req_data1 payloads;
//        grant one-hot capture pulse; sync_bus/bus_enable registered bus to the destination;
//        dest_ack asynchronous destination acknowledge; busy transfer in progress; timeout_err abort pulse.
module cdc_tx_arbiter
    import cdc_tx_arbiter_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [1:0]           req,
    input  logic [BUS_WIDTH-1:0] req_data0,
    input  logic [BUS_WIDTH-1:0] req_data1,
    output logic [1:0]           grant,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 bus_enable,
    input  logic                 dest_ack,
    output logic                 busy,
    output logic                 timeout_err
);
    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic [BUS_WIDTH-1:0] sync_bus_q, sync_bus_d;
    logic                 bus_enable_q, bus_enable_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                 last_q, last_d;
    logic                 armed_q, armed_d;
    logic                 ack_s, pick, expired;

    cdc_ack_sync #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (dest_ack),
        .q   (ack_s)
    );

    always_comb begin
        // Requester 1 wins when alone, or when both ask and requester 0 went last.
        pick         = (req == 2'b11) ? ~last_q : req[1];
        expired      = (state_q != IDLE) && (wait_cnt_q == WAIT_W'(TIMEOUT));
        state_d      = state_q;
        grant_d      = 2'b00;
        sync_bus_d   = sync_bus_q;
        bus_enable_d = bus_enable_q;
        last_d       = last_q;
        armed_d      = armed_q;
        wait_cnt_d   = (state_q == IDLE) ? '0 : wait_cnt_q + 1'b1;
        if (expired) begin
            state_d      = IDLE;
            bus_enable_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    armed_d = 1'b0;
                    if (|req) begin
                        state_d      = SEND;
                        grant_d      = pick ? 2'b10 : 2'b01;
                        sync_bus_d   = pick ? req_data1 : req_data0;
                        bus_enable_d = 1'b1;
                        last_d       = pick;
                    end
                end
                SEND: begin
                    // A stale high ack must be seen low once before its rise counts.
                    armed_d = armed_q | ~ack_s;
                    if (ack_s && armed_q) begin
                        state_d      = RELEASE;
                        bus_enable_d = 1'b0;
                    end
                end
                RELEASE: state_d = ack_s ? RELEASE : IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (state_d != state_q) wait_cnt_d = '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            sync_bus_q   <= '0;
            bus_enable_q <= 1'b0;
            wait_cnt_q   <= '0;
            last_q       <= 1'b1;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            sync_bus_q   <= sync_bus_d;
            bus_enable_q <= bus_enable_d;
            wait_cnt_q   <= wait_cnt_d;
            last_q       <= last_d;
            armed_q      <= armed_d;
        end
    end

    assign grant       = grant_q;
    assign sync_bus    = sync_bus_q;
    assign bus_enable  = bus_enable_q;
    assign busy        = state_q != IDLE;
    assign timeout_err = expired;
endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// tb_cdc_tx_arbiter: scoreboard bench for cdc_tx_arbiter
// Expected grants are queued when requests are driven and popped by a monitor when grant pulses.
module tb_cdc_tx_arbiter;
    typedef struct {
        logic [1:0] g;
        logic [7:0] d;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] req_data0 = 8'h00;
    logic [7:0] req_data1 = 8'h00;
    logic [1:0] grant;
    logic [7:0] sync_bus;
    logic       bus_enable;
    logic       dest_ack;
    logic       busy;
    logic       timeout_err;
    logic       ack_mode = 1'b0;
    logic       ack_man  = 1'b0;
    logic [2:0] dly = 3'b000;
    int         passed = 0;
    int         total  = 0;
    exp_t       sb[$];
    exp_t       mon_e;

    cdc_tx_arbiter #(.BUS_WIDTH(8), .NUM_STAGES(2), .TIMEOUT(10)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req         (req),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .grant       (grant),
        .sync_bus    (sync_bus),
        .bus_enable  (bus_enable),
        .dest_ack    (dest_ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 CLK = ~CLK;

    // Destination model: echo bus_enable three cycles late, or follow the manual level.
    assign dest_ack = ack_mode ? ack_man : dly[2];

    always @(posedge CLK) begin
        #1;
        dly = {dly[1:0], bus_enable};
        if (RST && grant != 2'b00) begin
            total++;
            if (sb.size() == 0)
                $display("FAIL unexpected_grant: got grant=%b bus=%h, required no grant", grant, sync_bus);
            else begin
                mon_e = sb.pop_front();
                if (grant !== mon_e.g || sync_bus !== mon_e.d)
                    $display("FAIL grant_data: got grant=%b bus=%h, required grant=%b bus=%h",
                             grant, sync_bus, mon_e.g, mon_e.d);
                else passed++;
            end
        end
    end

    task automatic cycle();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && busy; i++) cycle();
        total++;
        if (busy !== 1'b0) $display("FAIL %s_idle: got busy=%b, required 0", name, busy);
        else passed++;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({grant, sync_bus, bus_enable, busy, timeout_err} !== 13'b0)
            $display("FAIL reset_state: got grant=%b bus=%h en=%b busy=%b te=%b, required all 0",
                     grant, sync_bus, bus_enable, busy, timeout_err);
        else passed++;
        repeat (3) cycle();
        RST = 1'b1;
        cycle();
    endtask

    task automatic test_contention();
        ack_mode  = 1'b0;
        req_data0 = 8'h11;
        req_data1 = 8'h22;
        sb.push_back('{2'b01, 8'h11});
        sb.push_back('{2'b10, 8'h22});
        sb.push_back('{2'b01, 8'h11});
        req = 2'b11;
        for (int i = 0; i < 200 && sb.size() != 0; i++) cycle();
        req = 2'b00;
        total++;
        if (sb.size() != 0) $display("FAIL contention_done: got %0d pending grants, required 0", sb.size());
        else passed++;
        wait_idle("contention");
    endtask

    task automatic test_single();
        logic bad;
        ack_mode  = 1'b0;
        req_data0 = 8'hA5;
        req_data1 = 8'h5A;
        sb.push_back('{2'b01, 8'hA5});
        req = 2'b01;
        cycle();
        req = 2'b00;
        total++;
        if (grant !== 2'b01 || bus_enable !== 1'b1 || busy !== 1'b1)
            $display("FAIL single_latency: got grant=%b en=%b busy=%b, required 01 1 1", grant, bus_enable, busy);
        else passed++;
        cycle();
        total++;
        if (grant !== 2'b00) $display("FAIL single_pulse: got grant=%b, required 00", grant);
        else passed++;
        bad = 1'b0;
        for (int i = 0; i < 40 && busy; i++) begin
            if (sync_bus !== 8'hA5) bad = 1'b1;
            cycle();
        end
        total++;
        if (bad) $display("FAIL single_hold: got sync_bus changing, required A5 throughout");
        else passed++;
        wait_idle("single");
    endtask

    task automatic test_timeout();
        ack_mode  = 1'b1;
        ack_man   = 1'b0;
        req_data1 = 8'h3C;
        sb.push_back('{2'b10, 8'h3C});
        req = 2'b10;
        cycle();
        req = 2'b00;
        repeat (9) cycle();
        total++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_early: got te=%b, required 0", timeout_err);
        else passed++;
        cycle();
        total++;
        if (timeout_err !== 1'b1 || busy !== 1'b1)
            $display("FAIL timeout_pulse: got te=%b busy=%b, required 1 1", timeout_err, busy);
        else passed++;
        cycle();
        total++;
        if (timeout_err !== 1'b0 || bus_enable !== 1'b0 || busy !== 1'b0)
            $display("FAIL timeout_abort: got te=%b en=%b busy=%b, required 0 0 0", timeout_err, bus_enable, busy);
        else passed++;
        ack_mode  = 1'b0;
        req_data0 = 8'h77;
        sb.push_back('{2'b01, 8'h77});
        req = 2'b11;
        cycle();
        req = 2'b00;
        total++;
        if (grant !== 2'b01) $display("FAIL timeout_pointer: got grant=%b, required 01", grant);
        else passed++;
        wait_idle("timeout");
    endtask

    task automatic test_late_req();
        ack_mode  = 1'b0;
        req_data0 = 8'h0F;
        req_data1 = 8'hF0;
        sb.push_back('{2'b01, 8'h0F});
        req = 2'b01;
        cycle();
        req = 2'b10;
        for (int i = 0; i < 40 && busy; i++) cycle();
        sb.push_back('{2'b10, 8'hF0});
        cycle();
        req = 2'b00;
        total++;
        if (grant !== 2'b10) $display("FAIL late_grant: got grant=%b, required 10", grant);
        else passed++;
        wait_idle("late");
    endtask

    task automatic test_stale_ack();
        ack_mode  = 1'b1;
        ack_man   = 1'b1;
        req_data0 = 8'hC3;
        repeat (4) cycle();
        sb.push_back('{2'b01, 8'hC3});
        req = 2'b01;
        cycle();
        req = 2'b00;
        repeat (3) cycle();
        total++;
        if (bus_enable !== 1'b1) $display("FAIL stale_high: got en=%b, required 1", bus_enable);
        else passed++;
        ack_man = 1'b0;
        repeat (3) cycle();
        total++;
        if (bus_enable !== 1'b1) $display("FAIL stale_low: got en=%b, required 1", bus_enable);
        else passed++;
        ack_man = 1'b1;
        for (int i = 0; i < 6 && bus_enable; i++) cycle();
        total++;
        if (bus_enable !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0)
            $display("FAIL stale_release: got en=%b busy=%b te=%b, required 0 1 0", bus_enable, busy, timeout_err);
        else passed++;
        ack_man = 1'b0;
        wait_idle("stale");
        ack_mode = 1'b0;
    endtask

    task automatic test_mid_reset();
        ack_mode  = 1'b0;
        req_data0 = 8'h99;
        req_data1 = 8'h66;
        sb.push_back('{2'b10, 8'h66});
        req = 2'b11;
        cycle();
        req = 2'b00;
        for (int i = 0; i < 20 && bus_enable; i++) cycle();
        total++;
        if (busy !== 1'b1 || bus_enable !== 1'b0)
            $display("FAIL midrst_release: got busy=%b en=%b, required 1 0", busy, bus_enable);
        else passed++;
        RST = 1'b0;
        #1;
        total++;
        if ({grant, sync_bus, bus_enable, busy, timeout_err} !== 13'b0)
            $display("FAIL midrst_clear: got grant=%b bus=%h en=%b busy=%b te=%b, required all 0",
                     grant, sync_bus, bus_enable, busy, timeout_err);
        else passed++;
        repeat (4) cycle();
        RST = 1'b1;
        cycle();
        sb.push_back('{2'b01, 8'h99});
        req = 2'b11;
        cycle();
        req = 2'b00;
        total++;
        if (grant !== 2'b01) $display("FAIL midrst_first: got grant=%b, required 01", grant);
        else passed++;
        wait_idle("midrst");
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_timeout();
        test_late_req();
        test_stale_ack();
        test_mid_reset();
        repeat (3) cycle();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d pending grants, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1);
    end
endmodule
